// File: rtl/tpu_fifo_pkg.sv
// Shared constants and helpers for the sfifo read-side stream logic.
package tpu_fifo_pkg;

  localparam int RD_LATENCY  = 1;
  localparam int SKID_DEPTH  = 2;
  localparam int SKID_CNT_W  = $clog2(SKID_DEPTH + 1);
  localparam int STALL_CNT_W = 16;

  // Beat counter width: enough bits to hold 0..n-1, never narrower than 1.
  function automatic int beat_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready skid buffer with push, pop and synchronous flush.
// The head entry always drives dout; valid is simply "not empty".
module stream_skid2
  import tpu_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic                  valid,
  output logic [WIDTH-1:0]      dout,
  output logic [SKID_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      head;
  logic [WIDTH-1:0]      tail;
  logic [SKID_CNT_W-1:0] cnt;

  // Storage and occupancy; a simultaneous push and pop keeps the count and shifts the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == '0) head <= din;
          else           tail <= din;
          cnt <= cnt + SKID_CNT_W'(1);
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - SKID_CNT_W'(1);
        end
        2'b11: begin
          if (cnt == SKID_CNT_W'(1)) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (cnt != '0);
  assign dout  = head;
  assign count = cnt;

endmodule

// File: rtl/sfifo_rd_stream.sv
// Read-side drain engine for sfifo: pops the FIFO (1-cycle read latency),
// buffers returned words in a 2-entry skid and frames them into bursts of
// BURST_LEN beats with a last marker.
// Optional build macro SFIFO_RD_STALL_CNT_EN adds a saturating stall_cnt output.
module sfifo_rd_stream
  import tpu_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   fifo_rempty,
  output logic                   fifo_rinc,
  input  logic [WIDTH-1:0]       fifo_rdata,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last
`ifdef SFIFO_RD_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int               CNT_W    = beat_cnt_w(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  logic                  inflight;
  logic [SKID_CNT_W-1:0] buf_cnt;
  logic                  xfer;
  logic [2:0]            occ_after;
  logic [CNT_W-1:0]      beat_cnt;

  assign xfer = m_valid && m_ready;

  // Occupancy the skid would have after this cycle if no new pop were issued.
  // A transfer implies buf_cnt >= 1, so this never underflows.
  assign occ_after = 3'(buf_cnt) + 3'(inflight) - 3'(xfer);

  assign fifo_rinc = rst_n && !fifo_rempty && !clr && (occ_after < 3'(SKID_DEPTH));

  // A pop issued this cycle returns data RD_LATENCY cycle later; remember it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   inflight <= 1'b0;
    else if (clr) inflight <= 1'b0;
    else          inflight <= fifo_rinc;
  end

  // Returned FIFO data lands in the skid; flush drops anything still returning.
  stream_skid2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (inflight),
    .din   (fifo_rdata),
    .pop   (xfer),
    .valid (m_valid),
    .dout  (m_data),
    .count (buf_cnt)
  );

  // Beat index within the burst; holds across underflow gaps, wraps after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
    end else if (xfer) begin
      if (beat_cnt == LAST_IDX) beat_cnt <= '0;
      else                      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  assign m_last = m_valid && (beat_cnt == LAST_IDX);

`ifdef SFIFO_RD_STALL_CNT_EN
  // Saturating count of cycles where a beat is offered but not accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Testbench for sfifo_rd_stream (BURST_LEN=4). A queue-based FIFO model feeds
// the DUT; an ordered scoreboard plus a burst-position counter predict every beat.
// Build with SFIFO_RD_STALL_CNT_EN defined to also exercise stall_cnt.
module tb_sfifo_rd_stream;

  localparam int W  = 8;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         fifo_rempty = 1'b1;
  logic         fifo_rinc;
  logic [W-1:0] fifo_rdata = 8'hEE;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
`ifdef SFIFO_RD_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  sfifo_rd_stream #(
    .WIDTH     (W),
    .BURST_LEN (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .fifo_rempty (fifo_rempty),
    .fifo_rinc   (fifo_rinc),
    .fifo_rdata  (fifo_rdata),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last)
`ifdef SFIFO_RD_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Source FIFO contents, words popped but not yet delivered, and delivery logs.
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic [8:0]   out_log[$];
  int           out_cyc[$];
  int           rinc_cyc[$];
  int           cyc = 0;
  int           beat = 0;
  int           stall_m = 0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  // FIFO model: pop with 1-cycle read latency, empty flag follows contents.
  always @(posedge clk) begin
    logic [W-1:0] v;
    if (fifo_rinc) begin
      chk("pop_on_empty", 32'(fifo_rempty), 32'd0);
      if (fq.size() != 0) begin
        v = fq.pop_front();
        fifo_rdata <= v;
        exp_q.push_back(v);
      end
    end else begin
      fifo_rdata <= 8'hEE;
    end
    fifo_rempty <= (fq.size() == 0);
  end

  // Compare process: every cycle, mid-way between active edges.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_fifo_rinc", 32'(fifo_rinc), 32'd0);
      exp_q.delete();
      beat      = 0;
      stall_m   = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
      chk("skid_capacity", 32'(exp_q.size() <= 2), 32'd1);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          chk("beat_data", 32'(m_data), 32'(exp_q[0]));
          chk("beat_last", 32'(m_last), 32'(beat == BL - 1));
        end
      end else begin
        chk("idle_last", 32'(m_last), 32'd0);
      end
`ifdef SFIFO_RD_STALL_CNT_EN
      chk("stall_cnt_model", 32'(stall_cnt), 32'(stall_m));
`endif
      if (fifo_rinc) rinc_cyc.push_back(cyc);
      if (clr) begin
        chk("clr_rinc", 32'(fifo_rinc), 32'd0);
        exp_q.delete();
        beat    = 0;
        stall_m = 0;
      end else begin
        if (m_valid && m_ready) begin
          out_log.push_back({m_last, m_data});
          out_cyc.push_back(cyc);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          beat = (beat + 1) % BL;
        end
        if (m_valid && !m_ready && stall_m < 16'hFFFF) stall_m++;
      end
      prev_hold = m_valid && !m_ready && !clr;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    fq.push_back(v);
  endtask

  task automatic clear_logs();
    out_log.delete();
    out_cyc.delete();
    rinc_cyc.delete();
  endtask

  // Delivered beats must be base, base+1, ... with m_last where mask has a 1.
  task automatic chk_log(input string name, input logic [7:0] base, input int n,
                         input logic [15:0] mask);
    chk({name, "_count"}, 32'(out_log.size()), 32'(n));
    for (int i = 0; i < n && i < out_log.size(); i++) begin
      chk({name, "_data"}, 32'(out_log[i][7:0]), 32'(base + 8'(i)));
      chk({name, "_last"}, 32'(out_log[i][8]), 32'(mask[i]));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    m_ready = 1'b0;
    tick(2);
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_data", 32'(m_data), 32'd0);
    chk("reset_m_last", 32'(m_last), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Streaming at full rate, two bursts.
    clear_logs();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    tick(1);
    chk("lat_c1_rinc", 32'(fifo_rinc), 32'd1);
    chk("lat_c1_valid", 32'(m_valid), 32'd0);
    tick(1);
    chk("lat_c2_valid", 32'(m_valid), 32'd0);
    tick(1);
    chk("lat_c3_valid", 32'(m_valid), 32'd1);
    chk("lat_c3_data", 32'(m_data), 32'h10);
    tick(10);
    chk_log("stream", 8'h10, 8, 16'b1000_1000);
    chk("stream_rinc_cycles", 32'(rinc_cyc.size()), 32'd8);
    if (rinc_cyc.size() == 8) chk("stream_rinc_span", 32'(rinc_cyc[7] - rinc_cyc[0]), 32'd7);
    if (out_cyc.size() == 8)  chk("stream_out_span", 32'(out_cyc[7] - out_cyc[0]), 32'd7);

    // Backpressure: only two pops while the sink stalls, head holds.
    clear_logs();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    tick(7);
    chk("bp_pops", 32'(6 - fq.size()), 32'd2);
    chk("bp_rinc", 32'(fifo_rinc), 32'd0);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'h20);
    m_ready = 1'b1;
    tick(12);
    chk_log("bp", 8'h20, 6, 16'b00_1000);

    // Idle clear to realign the burst position.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);

    // Underflow mid-burst: gap, burst position kept.
    clear_logs();
    push(8'h30);
    push(8'h31);
    tick(6);
    push(8'h32);
    push(8'h33);
    tick(8);
    chk_log("uflow", 8'h30, 4, 16'b1000);
    if (out_cyc.size() >= 4) chk("uflow_gap", 32'(out_cyc[2] - out_cyc[1] > 1), 32'd1);

    // Flush with one word buffered and one in flight.
    push(8'h4F);
    tick(6);
    m_ready = 1'b0;
    push(8'h50);
    push(8'h51);
    tick(3);
    chk("flush_pre_valid", 32'(m_valid), 32'd1);
    chk("flush_pre_data", 32'(m_data), 32'h50);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("flush_valid_next", 32'(m_valid), 32'd0);
    clear_logs();
    tick(3);
    chk("flush_discard", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    tick(10);
    chk_log("flush", 8'h40, 4, 16'b1000);

    // Asynchronous reset mid-burst.
    clear_logs();
    for (int i = 0; i < 10; i++) push(8'h60 + 8'(i));
    tick(5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_last", 32'(m_last), 32'd0);
    chk("arst_rinc", 32'(fifo_rinc), 32'd0);
    tick(2);
    rst_n = 1'b1;
    clear_logs();
    tick(14);
    chk_log("arst", 8'h64, 6, 16'b00_1000);

`ifdef SFIFO_RD_STALL_CNT_EN
    // Stall counter: ten stalled cycles, then cleared.
    m_ready = 1'b0;
    push(8'h70);
    tick(3);
    chk("stall_valid", 32'(m_valid), 32'd1);
    tick(10);
    chk("stall_ten", 32'(stall_cnt), 32'd10);
    m_ready = 1'b1;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("stall_clr", 32'(stall_cnt), 32'd0);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
